// File: rtl/seg_capture.sv
// Multiplexed active-low 7-segment bus receiver: reconstructs the displayed hex digits.
// Optional decimal-point capture is enabled by defining SEG_CAPTURE_DP_EN.
module seg_capture #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              segs_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_valid,
  output logic                    err,
  output logic [NUM_DIGITS-1:0]   dp
);

  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
`ifdef SEG_CAPTURE_DP_EN
  localparam int unsigned SW = 8;
`else
  localparam int unsigned SW = 7;
`endif
  localparam int unsigned KW = NUM_DIGITS + SW;

  typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [NUM_DIGITS-1:0]   r_an_n;
  logic [SW-1:0]           r_seg_n;
  logic [KW-1:0]           r_key;
  logic [NUM_DIGITS-1:0]   r_mask;

  logic [NUM_DIGITS-1:0]   w_sel;
  logic                    w_legal;
  logic [IW-1:0]           w_idx;
  logic [KW-1:0]           w_key;
  logic [4:0]              w_dec;
  logic [NUM_DIGITS-1:0]   w_mask_nx;
  logic                    w_commit;
  logic                    w_store;

  // Returns {match, nibble} for an active-high segment pattern g..a.
  function automatic logic [4:0] glyph_decode(input logic [6:0] p);
    case (p)
      7'h3F:   glyph_decode = {1'b1, 4'h0};
      7'h06:   glyph_decode = {1'b1, 4'h1};
      7'h5B:   glyph_decode = {1'b1, 4'h2};
      7'h4F:   glyph_decode = {1'b1, 4'h3};
      7'h66:   glyph_decode = {1'b1, 4'h4};
      7'h6D:   glyph_decode = {1'b1, 4'h5};
      7'h7D:   glyph_decode = {1'b1, 4'h6};
      7'h07:   glyph_decode = {1'b1, 4'h7};
      7'h7F:   glyph_decode = {1'b1, 4'h8};
      7'h6F:   glyph_decode = {1'b1, 4'h9};
      7'h77:   glyph_decode = {1'b1, 4'hA};
      7'h7C:   glyph_decode = {1'b1, 4'hB};
      7'h39:   glyph_decode = {1'b1, 4'hC};
      7'h5E:   glyph_decode = {1'b1, 4'hD};
      7'h79:   glyph_decode = {1'b1, 4'hE};
      7'h71:   glyph_decode = {1'b1, 4'hF};
      default: glyph_decode = 5'h00;
    endcase
  endfunction

  // Exactly one anode low is a legal selection; anything else is blanking.
  assign w_sel     = ~r_an_n;
  assign w_legal   = (w_sel != '0) && ((w_sel & (w_sel - NUM_DIGITS'(1))) == '0);
  assign w_key     = {r_an_n, r_seg_n};
  assign w_dec     = glyph_decode(~r_seg_n[6:0]);
  assign w_mask_nx = r_mask | w_sel;
  assign w_commit  = w_legal && (r_state == TRACK) && (w_key == r_key) &&
                     (r_cnt == CW'(STABLE_CYCLES - 1));
  assign w_store   = w_commit && w_dec[4];

  always_comb begin
    w_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!r_an_n[i]) w_idx = IW'(i);
    end
  end

  // Sample register, dwell FSM and commit of the decoded digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an_n      <= '1;
      r_seg_n     <= '1;
      r_key       <= '1;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mask      <= '0;
      value       <= '0;
      digit_valid <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      r_an_n      <= an_n;
      r_seg_n     <= segs_n[SW-1:0];
      r_key       <= w_key;
      frame_valid <= 1'b0;
      err         <= 1'b0;
      if (!w_legal) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else if (r_state == IDLE || w_key != r_key) begin
        r_state <= TRACK;
        r_cnt   <= CW'(1);
      end else if (r_state == TRACK) begin
        if (w_commit) begin
          r_state <= HELD;
          r_cnt   <= CW'(STABLE_CYCLES);
          if (w_store) begin
            value[32'(w_idx)*4 +: 4] <= w_dec[3:0];
            digit_valid <= digit_valid | w_sel;
            if (&w_mask_nx) begin
              frame_valid <= 1'b1;
              r_mask      <= '0;
            end else begin
              r_mask <= w_mask_nx;
            end
          end else begin
            err <= 1'b1;
          end
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

`ifdef SEG_CAPTURE_DP_EN
  logic [NUM_DIGITS-1:0] r_dp;

  always_ff @(posedge clk) begin
    if (rst)          r_dp        <= '0;
    else if (w_store) r_dp[w_idx] <= ~r_seg_n[7];
  end

  assign dp = r_dp;
`else
  logic w_unused_dp;

  assign w_unused_dp = segs_n[7];
  assign dp          = '0;
`endif

endmodule

// File: tb/tb_seg_capture.sv
// Scoreboard bench for seg_capture: driver queues expected output events, monitor checks them.
module tb_seg_capture;

  localparam int unsigned ND = 4;
  localparam int unsigned SC = 4;
`ifdef SEG_CAPTURE_DP_EN
  localparam logic [3:0] DP3 = 4'b1000;
`else
  localparam logic [3:0] DP3 = 4'b0000;
`endif

  typedef struct {
    int         cyc;
    logic [15:0] v;
    logic [3:0]  dv;
    logic        fv;
    logic        er;
    logic [3:0]  dp;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    segs_n;
  logic [ND-1:0] an_n;
  logic [15:0]   value;
  logic [ND-1:0] digit_valid;
  logic          frame_valid;
  logic          err;
  logic [ND-1:0] dp;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;
  exp_t q[$];

  seg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .segs_n(segs_n), .an_n(an_n),
    .value(value), .digit_valid(digit_valid), .frame_valid(frame_valid),
    .err(err), .dp(dp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input int dcyc, input logic [15:0] v, input logic [3:0] dv,
                          input logic fv, input logic er, input logic [3:0] d);
    exp_t e;
    e.cyc = cyc + dcyc; e.v = v; e.dv = dv; e.fv = fv; e.er = er; e.dp = d;
    q.push_back(e);
  endtask

  // Called at a falling edge: apply a pair and hold it for n cycles.
  task automatic drive(input logic [3:0] a, input logic [7:0] s, input int n);
    an_n   = a;
    segs_n = s;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any pulse or change of the captured outputs is one event.
  logic [15:0] last_v;
  logic [3:0]  last_dv;
  logic [3:0]  last_dp;
  always @(negedge clk) begin
    if (mon_en) begin
      if (frame_valid || err || value != last_v || digit_valid != last_dv || dp != last_dp) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event cycle=%0d value=%0h dv=%0h fv=%0b err=%0b dp=%0h",
                   cyc, value, digit_valid, frame_valid, err, dp);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("event_cycle", 32'(cyc), 32'(e.cyc));
          check("value", 32'(value), 32'(e.v));
          check("digit_valid", 32'(digit_valid), 32'(e.dv));
          check("frame_valid", 32'(frame_valid), 32'(e.fv));
          check("err", 32'(err), 32'(e.er));
          check("dp", 32'(dp), 32'(e.dp));
        end
      end
      last_v  = value;
      last_dv = digit_valid;
      last_dp = dp;
    end
  end

  localparam int LAT = SC + 1;

  initial begin
    logic [6:0] g [4];
    g[0] = 7'h3F; g[1] = 7'h06; g[2] = 7'h5B; g[3] = 7'h4F;
    rst = 1'b1; an_n = '1; segs_n = '1;
    repeat (3) @(negedge clk);
    check("rst_value", 32'(value), 32'h0);
    check("rst_digit_valid", 32'(digit_valid), 32'h0);
    check("rst_frame_valid", 32'(frame_valid), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_dp", 32'(dp), 32'h0);
    last_v = '0; last_dv = '0; last_dp = '0;
    rst = 1'b0;
    mon_en = 1'b1;
    drive(4'hF, 8'hFF, 2);

    // Stable all-off pattern on digit 0: error pulse, nothing captured.
    push_exp(LAT, 16'h0000, 4'h0, 1'b0, 1'b1, 4'h0);
    drive(4'b1110, 8'hFF, SC);
    drive(4'hF, 8'hFF, 2);

    // Scan digits 0..3 showing 0,1,2,3; frame completes on the last commit.
    for (int i = 0; i < 4; i++) begin
      logic [15:0] v;
      logic [3:0]  dvx;
      v   = 16'h3210 & ((16'h1 << (4 * (i + 1))) - 16'h1);
      dvx = 4'((5'h1 << (i + 1)) - 5'h1);
      push_exp(LAT, v, dvx, (i == 3), 1'b0, 4'h0);
      drive(~4'(1 << i), {1'b1, ~g[i]}, SC);
    end
    drive(4'hF, 8'hFF, 2);

    // Too-short dwell on digit 2 never commits.
    drive(4'b1011, {1'b1, ~7'h7C}, SC - 1);
    drive(4'hF, 8'hFF, 4);

    // Long dwell on digit 1 commits exactly once.
    push_exp(LAT, 16'h32A0, 4'hF, 1'b0, 1'b0, 4'h0);
    drive(4'b1101, {1'b1, ~7'h77}, 20);
    drive(4'hF, 8'hFF, 2);

    // Two anodes low is blanking.
    drive(4'b0011, {1'b1, ~7'h3F}, 10);
    drive(4'hF, 8'hFF, 2);

    // Digit 3 shows E with decimal point lit.
    push_exp(LAT, 16'hE2A0, 4'hF, 1'b0, 1'b0, DP3);
    drive(4'b0111, {1'b0, ~7'h79}, SC);

    // Digits 0 and 2 complete the frame that digits 1 and 3 started.
    push_exp(LAT, 16'hE2A6, 4'hF, 1'b0, 1'b0, DP3);
    drive(4'b1110, {1'b1, ~7'h7D}, SC);
    push_exp(LAT, 16'hE9A6, 4'hF, 1'b1, 1'b0, DP3);
    drive(4'b1011, {1'b1, ~7'h6F}, SC);

    // Reset mid-dwell clears everything; capture then restarts from scratch.
    drive(4'b1110, {1'b1, ~7'h06}, 2);
    push_exp(1, 16'h0000, 4'h0, 1'b0, 1'b0, 4'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push_exp(LAT, 16'h0001, 4'h1, 1'b0, 1'b0, 4'h0);
    drive(4'b1110, {1'b1, ~7'h06}, SC + 2);
    drive(4'hF, 8'hFF, 10);

    check("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
